// File: rtl/store_buffer_if.sv
// Bus between the MEM stage, the store buffer and the unified memory data port.
// master = pipeline/memory side, slave = store buffer.
interface store_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  misaligned;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic                  mem_re;
    logic [2:0]            mem_load_type;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, misaligned, empty,
               mem_addr, mem_wdata, mem_we, mem_be, mem_re, mem_load_type
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, misaligned, empty,
               mem_addr, mem_wdata, mem_we, mem_be, mem_re, mem_load_type
    );
endinterface

// File: rtl/store_buffer.sv
// Store FIFO plus data-port arbiter: loads win the port, buffered stores drain
// in otherwise idle cycles, loads overlapping a buffered store stall.
module store_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = ADDR_WIDTH + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            be;
    } entry_t;

    entry_t                entries [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  rsp_valid_q;
    logic                  misaligned_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic [1:0]            size_code;
    logic [2:0]            req_size;
    logic [3:0]            req_be;
    logic                  bad;
    logic [SUM_W-1:0]      req_lo;
    logic [SUM_W-1:0]      req_hi;
    logic [PTR_W-1:0]      rel [DEPTH];
    logic [DEPTH-1:0]      hit;
    logic                  hazard;
    logic                  full;
    logic                  load_go;
    logic                  store_go;
    logic                  drain_go;

    function automatic logic [2:0] be_size(input logic [3:0] be);
        if (be[3])      return 3'd4;
        else if (be[1]) return 3'd2;
        else            return 3'd1;
    endfunction

    assign size_code = bus.req_funct3[1:0];

    // Access size and byte enables from funct3
    always_comb begin
        req_size = 3'd1;
        req_be   = 4'b0001;
        case (size_code)
            2'b01:   begin req_size = 3'd2; req_be = 4'b0011; end
            2'b10:   begin req_size = 3'd4; req_be = 4'b1111; end
            default: ;
        endcase
    end

    // Misaligned or unsupported encodings are accepted but never performed
    always_comb begin
        bad = 1'b0;
        if (size_code == 2'b01 && bus.req_addr[0])           bad = 1'b1;
        if (size_code == 2'b10 && bus.req_addr[1:0] != 2'b00) bad = 1'b1;
        if (bus.req_write && bus.req_funct3 > 3'b010)         bad = 1'b1;
        if (!bus.req_write &&
            (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11)) bad = 1'b1;
    end

    // Byte-range overlap against every live entry; one extra bit keeps ranges from wrapping
    assign req_lo = SUM_W'(bus.req_addr);
    assign req_hi = req_lo + SUM_W'(req_size);

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rel[i] = PTR_W'(i) - head;
            if (CNT_W'(rel[i]) < count
                && req_lo < SUM_W'(entries[i].addr) + SUM_W'(be_size(entries[i].be))
                && SUM_W'(entries[i].addr) < req_hi)
                hit[i] = 1'b1;
        end
    end

    assign hazard   = |hit;
    assign full     = (count == CNT_W'(DEPTH));
    assign load_go  = bus.req_valid && !bus.req_write && !bad && !hazard;
    assign store_go = bus.req_valid && bus.req_write && !bad && !full;
    assign drain_go = !load_go && (count != '0);

    assign bus.req_ready  = !bus.req_valid || bad || (bus.req_write ? !full : !hazard);
    assign bus.empty      = (count == '0);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.misaligned = misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            if (store_go) tail <= tail + PTR_W'(1);
            if (drain_go) head <= head + PTR_W'(1);
            count        <= count + CNT_W'(store_go) - CNT_W'(drain_go);
            rsp_valid_q  <= load_go;
            misaligned_q <= bus.req_valid && bad;
            if (load_go) rsp_data_q <= bus.mem_rdata;
        end
    end

    // Payload storage needs no reset: liveness is tracked by head/count
    always_ff @(posedge clk) begin
        if (store_go) begin
            entries[tail].addr <= bus.req_addr;
            entries[tail].data <= bus.req_wdata;
            entries[tail].be   <= req_be;
        end
    end

    // Data-port mux: issuing load first, otherwise the head entry drains
    always_comb begin
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_be        = 4'b0000;
        bus.mem_we        = 1'b0;
        bus.mem_re        = 1'b0;
        bus.mem_load_type = 3'b000;
        if (load_go) begin
            bus.mem_addr      = bus.req_addr;
            bus.mem_re        = 1'b1;
            bus.mem_load_type = bus.req_funct3;
        end else if (drain_go) begin
            bus.mem_addr  = entries[head].addr;
            bus.mem_wdata = entries[head].data;
            bus.mem_be    = entries[head].be;
            bus.mem_we    = 1'b1;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte-addressed memory model, vector table, directed
// corner sequences and a randomized run against an architectural model.
module tb_store_buffer;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned N_RAND = 3000;
    localparam int unsigned N_VEC  = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem_bytes [0:65535];
    logic [7:0]  arch      [0:65535];
    logic [15:0] ma;
    int          n_total = 0;
    int          n_pass  = 0;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        exp_ready;
        logic        exp_mis;
        logic        exp_rv;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [N_VEC];

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b01:   return 32'd2;
            2'b10:   return 32'd4;
            default: return 32'd1;
        endcase
    endfunction

    function automatic logic is_bad(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b01 && a[0])            return 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        if (w && f3 > 3'b010)                    return 1'b1;
        if (!w && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) return 1'b1;
        return 1'b0;
    endfunction

    // Memory: combinational extended read, byte-enabled write on the edge
    assign ma = bus.mem_addr[15:0];
    assign bus.mem_rdata = ext_load(bus.mem_load_type,
        {mem_bytes[ma + 16'd3], mem_bytes[ma + 16'd2], mem_bytes[ma + 16'd1], mem_bytes[ma]});

    initial for (int i = 0; i < 65536; i++) mem_bytes[i] <= 8'(i);

    always @(posedge clk)
        if (bus.mem_we)
            for (int k = 0; k < 4; k++)
                if (bus.mem_be[k]) mem_bytes[ma + 16'(k)] <= bus.mem_wdata[8*k +: 8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sb_data [4];
        logic [31:0] q_lo [$];
        logic [31:0] q_sz [$];
        logic        rv, rw, bd, ovl, ld, st, exp_ready;
        logic [2:0]  rf3;
        logic [31:0] ra, rd, sz, exp_data;
        logic [15:0] a16;

        rst = 1'b1;
        idle();
        for (int i = 0; i < 65536; i++) arch[i] = 8'(i);
        sb_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        vt[0]  = '{1'b0, 3'b010, 32'h2004, 1'b1, 1'b0, 1'b1, 32'h07060504};
        vt[1]  = '{1'b0, 3'b000, 32'h2083, 1'b1, 1'b0, 1'b1, 32'hFFFFFF83};
        vt[2]  = '{1'b0, 3'b100, 32'h2083, 1'b1, 1'b0, 1'b1, 32'h00000083};
        vt[3]  = '{1'b0, 3'b001, 32'h2082, 1'b1, 1'b0, 1'b1, 32'hFFFF8382};
        vt[4]  = '{1'b0, 3'b101, 32'h2086, 1'b1, 1'b0, 1'b1, 32'h00008786};
        vt[5]  = '{1'b0, 3'b010, 32'h1001, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 3'b001, 32'h1001, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 3'b011, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 3'b110, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 3'b111, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[10] = '{1'b1, 3'b001, 32'h1003, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b1, 3'b010, 32'h1002, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b1, 3'b011, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b1, 3'b100, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0};

        // Reset defaults, sampled while reset is still held
        repeat (2) @(posedge clk);
        #1;
        chkb("reset_empty", bus.empty, 1'b1);
        chkb("reset_ready", bus.req_ready, 1'b1);
        chkb("reset_mem_we", bus.mem_we, 1'b0);
        chkb("reset_mem_re", bus.mem_re, 1'b0);
        chkb("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chkb("reset_misaligned", bus.misaligned, 1'b0);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        rst = 1'b0;
        #1;

        // Single-request vectors from an empty buffer
        for (int i = 0; i < int'(N_VEC); i++) begin
            drive(1'b1, vt[i].w, vt[i].f3, vt[i].addr, 32'h12345678);
            #1;
            chkb($sformatf("tbl%0d_ready", i), bus.req_ready, vt[i].exp_ready);
            tick();
            idle();
            chkb($sformatf("tbl%0d_rsp_valid", i), bus.rsp_valid, vt[i].exp_rv);
            chkb($sformatf("tbl%0d_misaligned", i), bus.misaligned, vt[i].exp_mis);
            if (vt[i].exp_rv) chk($sformatf("tbl%0d_rsp_data", i), bus.rsp_data, vt[i].exp_data);
            #1;
            chkb($sformatf("tbl%0d_empty", i), bus.empty, 1'b1);
        end

        // Store/load round trip: the unrelated load takes the port before the drain
        drive(1'b1, 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF);
        #1; chkb("rt_sw_ready", bus.req_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 3'b010, 32'h2000, 32'h0);
        #1;
        chkb("rt_ld_re", bus.mem_re, 1'b1);
        chkb("rt_ld_no_we", bus.mem_we, 1'b0);
        chkb("rt_ld_empty", bus.empty, 1'b0);
        tick();
        idle();
        chkb("rt_ld_rsp_valid", bus.rsp_valid, 1'b1);
        chk("rt_ld_rsp_data", bus.rsp_data, 32'h03020100);
        #1;
        chkb("rt_drain_we", bus.mem_we, 1'b1);
        chk("rt_drain_addr", bus.mem_addr, 32'h1000);
        chk("rt_drain_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("rt_drain_be", 32'(bus.mem_be), 32'hF);
        tick();
        chkb("rt_empty_after", bus.empty, 1'b1);
        drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        #1; tick(); idle();
        chk("rt_readback", bus.rsp_data, 32'hDEADBEEF);

        // Hazard stall: overlapping LB waits for the SH to drain
        drive(1'b1, 1'b1, 3'b001, 32'h1002, 32'h00008001);
        #1; chkb("hz_sh_ready", bus.req_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0);
        #1;
        chkb("hz_stall_ready", bus.req_ready, 1'b0);
        chkb("hz_stall_we", bus.mem_we, 1'b1);
        chk("hz_stall_addr", bus.mem_addr, 32'h1002);
        chk("hz_stall_be", 32'(bus.mem_be), 32'h3);
        tick();
        chkb("hz_release_ready", bus.req_ready, 1'b1);
        chkb("hz_release_re", bus.mem_re, 1'b1);
        chkb("hz_release_rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        idle();
        chkb("hz_rsp_valid", bus.rsp_valid, 1'b1);
        chk("hz_rsp_data", bus.rsp_data, 32'hFFFFFF80);
        #1;

        // Byte stores interleaved with loads; upper data bits must be masked by be
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b1, 3'b000, 32'h1010 + 32'(j), {24'hFFFFFF, sb_data[j]});
            #1; chkb($sformatf("fb_sb%0d_ready", j), bus.req_ready, 1'b1);
            tick();
            drive(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0);
            #1; chkb($sformatf("fb_lw%0d_empty", j), bus.empty, 1'b0);
            tick();
        end
        idle();
        chkb("fb_lw_rsp_valid", bus.rsp_valid, 1'b1);
        chk("fb_lw_rsp_data", bus.rsp_data, 32'h03020100);
        #1; chkb("fb_final_drain_we", bus.mem_we, 1'b1);
        tick();
        chkb("fb_empty_after", bus.empty, 1'b1);
        drive(1'b1, 1'b0, 3'b010, 32'h1010, 32'h0);
        #1; tick(); idle();
        chk("fb_readback", bus.rsp_data, 32'hD4C3B2A1);
        #1;

        // Reset with a store still queued discards it
        drive(1'b1, 1'b1, 3'b010, 32'h1120, 32'hCAFEF00D);
        #1; tick();
        drive(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0);
        #1; chkb("rq_empty_before", bus.empty, 1'b0);
        #2; rst = 1'b1;
        #1;
        chkb("rq_empty_in_reset", bus.empty, 1'b1);
        chkb("rq_we_in_reset", bus.mem_we, 1'b0);
        @(posedge clk);
        #1; rst = 1'b0; idle();
        #1; chkb("rq_rsp_valid_after", bus.rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 3'b010, 32'h1120, 32'h0);
        #1; tick(); idle();
        chk("rq_old_contents", bus.rsp_data, 32'h23222120);
        #1;

        // Randomized traffic in a small window against an architectural model
        for (int n = 0; n < int'(N_RAND); n++) begin
            rv  = ($urandom_range(0, 4) != 0);
            rw  = ($urandom_range(0, 1) == 1);
            rf3 = 3'($urandom_range(0, 7));
            ra  = 32'h4000 + 32'($urandom_range(0, 31));
            rd  = $urandom;
            drive(rv, rw, rf3, ra, rd);
            #1;
            sz  = size_of(rf3);
            bd  = is_bad(rw, rf3, ra);
            ovl = 1'b0;
            foreach (q_lo[j]) if (ra < q_lo[j] + q_sz[j] && q_lo[j] < ra + sz) ovl = 1'b1;
            exp_ready = !rv || bd || (rw ? (q_lo.size() < int'(DEPTH)) : !ovl);
            chkb("rand_ready", bus.req_ready, exp_ready);
            chkb("rand_empty", bus.empty, q_lo.size() == 0);
            ld = rv && !rw && !bd && !ovl;
            st = rv && rw && !bd && (q_lo.size() < int'(DEPTH));
            if (!ld && q_lo.size() > 0) begin
                void'(q_lo.pop_front());
                void'(q_sz.pop_front());
            end
            if (st) begin
                q_lo.push_back(ra);
                q_sz.push_back(sz);
                for (int k = 0; k < int'(sz); k++) arch[ra[15:0] + 16'(k)] = rd[8*k +: 8];
            end
            exp_data = 32'h0;
            if (ld) begin
                a16 = ra[15:0];
                exp_data = ext_load(rf3, {arch[a16 + 16'd3], arch[a16 + 16'd2],
                                          arch[a16 + 16'd1], arch[a16]});
            end
            tick();
            chkb("rand_rsp_valid", bus.rsp_valid, ld);
            chkb("rand_misaligned", bus.misaligned, rv && bd);
            if (ld) chk("rand_rsp_data", bus.rsp_data, exp_data);
        end

        idle();
        for (int c = 0; c < 8 && !bus.empty; c++) tick();
        chkb("rand_final_empty", bus.empty, 1'b1);

        // Word sweep of the random window against the architectural image
        for (int j = 0; j < 8; j++) begin
            ra = 32'h4000 + 32'(4 * j);
            a16 = ra[15:0];
            drive(1'b1, 1'b0, 3'b010, ra, 32'h0);
            #1; chkb("sweep_ready", bus.req_ready, 1'b1);
            tick(); idle();
            chk($sformatf("sweep_%0d_data", j), bus.rsp_data,
                {arch[a16 + 16'd3], arch[a16 + 16'd2], arch[a16 + 16'd1], arch[a16]});
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
